srt_divider_r2: RTL and testbench
=================================

Name: srt_divider_r2

Overview:
- Radix-2 SRT (non-restoring, redundant digit set {-1,0,+1}) sequential fractional divider.
- Computes a 4-bit quotient and a remainder for an 8-bit dividend over a normalized 4-bit divisor.
- Standalone arithmetic block, clocked; starts one division automatically on every reset release and flags completion with done.

Parameters:
- None. Widths are fixed constants in the shared package: K=4 (quotient bits), ZW=9, DW=5, PW=11 (partial-remainder width).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst=0 at a clk edge resets)
- z  in  9  dividend; z[7:0]=Z, value 0.z7..z0 (Z/256); z[8] must be 0
- d  in  5  divisor; d[3:0]=D, value 0.d3..d0 (D/16), normalized d[3]=1; d[4] must be 0
- q  out  4  quotient, unsigned integer = floor(Z/D)
- s  out  9  remainder, unsigned = Z - q*D, 0 <= s < D
- done  out  1  result valid; high until next reset

Behaviour:
- Valid domain: z[8]=0, d[4]=0, d[3]=1, Z < 16*D. Out of domain: latency and done timing are unchanged; q/s are unspecified and not checked.
- Reset (rst=0 at edge): q=0, s=0, done=0, P=0, Qp=Qn=0, count=0, state=LOAD. Reset mid-operation aborts and restarts from LOAD.
- FSM: LOAD -> ITER (4 cycles) -> FIX -> DONE. DONE holds until reset.
- Edge 1 after release, LOAD: capture P=sign-extended Z (11-bit signed), Dsh=D<<4, Qp=Qn=0. Inputs are ignored after LOAD.
- Edges 2-5, ITER (j = 3 down to 0):
  - T=2P.
  - T >= 128: digit +1, P=T-Dsh, Qp[j]=1.
  - T < -128: digit -1, P=T+Dsh, Qn[j]=1.
  - Otherwise: digit 0, P=T.
  - Selection needs only the top bits of T; an exact compare is equally acceptable.
- Edge 6, FIX: Qt=Qp-Qn.
  - If P<0: q=Qt-1, s=(P+Dsh)>>4.
  - Else: q=Qt, s=P>>4.
  - done=1 at this same edge.
- P is always a multiple of 16 at FIX, so the shift is exact. s is zero-extended to 9 bits.
- q, s, done change only at FIX or reset. Done latency is 6 rising edges after the first edge with rst=1.
- Invariant: |P| < Dsh <= 240 throughout; 11-bit signed arithmetic, no overflow.

Decomposition:
- Package srt_pkg: K, ZW, DW, PW, selection thresholds (+128/-128), state enum {LOAD, ITER, FIX, DONE}.
- One natural sub-module, srt_qsel: combinational digit selection, 2P -> {+1, 0, -1}.
- The top level holds the FSM, counter, P/Qp/Qn registers, and the conversion/correction logic.

Test Plan:
- z=117, d=14, release reset -> digits +1,0,0,0; q=8, s=5; done rises exactly at edge 6 and stays high.
- z=70, d=15 (negative path) -> digits +1,-1,0,+1, P4=-80 corrected; q=4, s=10.
- z=0, d=8 -> q=0, s=0. Also z=239, d=15 -> q=15, s=14 (max quotient).
- z=100, d=8 -> q=12, s=4. Change z/d after edge 1 -> result unchanged.
- Assert rst=0 during ITER (edge 3), release with z=117, d=14 -> outputs 0 and done=0 during reset, then q=8, s=5 six edges after release.
- Random in-domain sweep (all D in 8..15, Z < 16*D) -> q=floor(Z/D), s=Z mod D vs reference model.

Source files
------------

// File: rtl/srt_pkg.sv
// Shared widths, digit-selection thresholds and enums for the radix-2 SRT divider.
package srt_pkg;
    localparam int K  = 4;   // quotient bits
    localparam int ZW = 9;   // dividend port width
    localparam int DW = 5;   // divisor port width
    localparam int PW = 11;  // signed partial-remainder width

    localparam logic signed [PW-1:0] SEL_POS = 11'sd128;
    localparam logic signed [PW-1:0] SEL_NEG = -11'sd128;

    typedef enum logic [1:0] {
        LOAD,
        ITER,
        FIX,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DIG_ZERO = 2'b00,
        DIG_POS  = 2'b01,
        DIG_NEG  = 2'b10
    } digit_t;
endpackage

// File: rtl/srt_qsel.sv
// Radix-2 SRT quotient-digit selection: maps the doubled partial remainder to {+1, 0, -1}.
module srt_qsel
    import srt_pkg::*;
(
    input  logic signed [PW-1:0] t,
    output digit_t               digit
);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        digit = DIG_ZERO;
        if (t >= SEL_POS) begin
            digit = DIG_POS;
        end else if (t < SEL_NEG) begin
            digit = DIG_NEG;
        end
    end

endmodule

// File: rtl/srt_divider_r2.sv
// Sequential radix-2 SRT fractional divider: one division per reset release, result flagged by done.
module srt_divider_r2
    import srt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [ZW-1:0] z,
    input  logic [DW-1:0] d,
    output logic [K-1:0]  q,
    output logic [ZW-1:0] s,
    output logic          done
);

    state_t                 state;
    logic [$clog2(K)-1:0]   count;
    logic signed [PW-1:0]   p;
    logic signed [PW-1:0]   dsh;
    logic [K-1:0]           qp;
    logic [K-1:0]           qn;

    logic signed [PW-1:0]   t;
    logic signed [PW-1:0]   p_next;
    logic signed [PW-1:0]   rem;
    logic [K-1:0]           qt;
    digit_t                 digit;

    assign t = p <<< 1;

    srt_qsel u_qsel (
        .t     (t),
        .digit (digit)
    );

    always_comb begin
        p_next = t;
        case (digit)
            DIG_POS: p_next = t - dsh;
            DIG_NEG: p_next = t + dsh;
            default: p_next = t;
        endcase
    end

    // Redundant-to-binary conversion; a negative final remainder borrows one divisor back.
    always_comb begin
        qt  = qp - qn;
        rem = p[PW-1] ? (p + dsh) : p;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
            count <= '0;
            p     <= '0;
            dsh   <= '0;
            qp    <= '0;
            qn    <= '0;
            q     <= '0;
            s     <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    p     <= {{(PW-ZW){z[ZW-1]}}, z};
                    dsh   <= {{(PW-DW-4){1'b0}}, d, 4'b0000};
                    qp    <= '0;
                    qn    <= '0;
                    count <= $clog2(K)'(K-1);
                    state <= ITER;
                end
                ITER: begin
                    p <= p_next;
                    if (digit == DIG_POS) qp[count] <= 1'b1;
                    if (digit == DIG_NEG) qn[count] <= 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    q     <= p[PW-1] ? (qt - 4'd1) : qt;
                    s     <= ZW'(unsigned'(rem) >> 4);
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srt_divider_r2.sv
// Self-checking bench for srt_divider_r2: directed cases plus a random in-domain sweep vs floor division.
module tb_srt_divider_r2;

    logic       clk;
    logic       rst;
    logic [8:0] z;
    logic [4:0] d;
    logic [3:0] q;
    logic [8:0] s;
    logic       done;

    int errors = 0;
    int checks = 0;

    srt_divider_r2 dut (
        .clk  (clk),
        .rst  (rst),
        .z    (z),
        .d    (d),
        .q    (q),
        .s    (s),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset for one edge, release, then watch six edges; optionally scramble inputs after edge 1.
    task automatic run_one(input logic [7:0] zz, input logic [3:0] dd, input bit scramble,
                           input string name);
        int exp_q;
        int exp_s;
        logic [3:0] q_hold;
        logic [8:0] s_hold;
        exp_q = int'(zz) / int'(dd);
        exp_s = int'(zz) % int'(dd);

        @(negedge clk);
        rst = 1'b0;
        z   = {1'b0, zz};
        d   = {1'b0, dd};
        @(posedge clk);
        #1;
        checks++;
        if (q !== 4'd0 || s !== 9'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s reset: q=%0d s=%0d done=%b, required q=0 s=0 done=0",
                     name, q, s, done);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            if (e == 1 && scramble) begin
                z = 9'($urandom);
                d = 5'($urandom);
            end
            if (e < 6) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_done: done=%b at edge %0d, required 0", name, done, e);
                end
            end
        end

        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_edge6: done=%b, required 1", name, done);
        end
        checks++;
        if (q !== 4'(exp_q)) begin
            errors++;
            $display("FAIL %s q: got %0d, required %0d (z=%0d d=%0d)", name, q, exp_q, zz, dd);
        end
        checks++;
        if (s !== 9'(exp_s)) begin
            errors++;
            $display("FAIL %s s: got %0d, required %0d (z=%0d d=%0d)", name, s, exp_s, zz, dd);
        end

        q_hold = 4'(exp_q);
        s_hold = 9'(exp_s);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || q !== q_hold || s !== s_hold) begin
            errors++;
            $display("FAIL %s hold: done=%b q=%0d s=%0d, required done=1 q=%0d s=%0d",
                     name, done, q, s, q_hold, s_hold);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        z   = 9'd0;
        d   = 5'd8;
        @(posedge clk);
        #1;
        checks++;
        if (q !== 4'd0 || s !== 9'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: q=%0d s=%0d done=%b, required 0 0 0", q, s, done);
        end
    endtask

    task automatic test_directed();
        run_one(8'd117, 4'd14, 1'b0, "pos_path");
        run_one(8'd70,  4'd15, 1'b0, "neg_path");
        run_one(8'd0,   4'd8,  1'b0, "zero");
        run_one(8'd239, 4'd15, 1'b0, "max_q");
        run_one(8'd100, 4'd8,  1'b0, "z100_d8");
        run_one(8'd127, 4'd8,  1'b0, "edge_z127_d8");
    endtask

    task automatic test_input_ignore();
        run_one(8'd100, 4'd8,  1'b1, "ignore_inputs");
        run_one(8'd70,  4'd15, 1'b1, "ignore_inputs_neg");
    endtask

    // Abort a division during ITER, then confirm a clean restart.
    task automatic test_mid_reset();
        @(negedge clk);
        rst = 1'b0;
        z   = 9'd239;
        d   = 5'd15;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        run_one(8'd117, 4'd14, 1'b0, "mid_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 48; i++) begin
            logic [3:0] dd;
            logic [7:0] zz;
            dd = 4'(8 + (i % 8));
            zz = 8'($urandom_range(0, 16 * int'(dd) - 1));
            run_one(zz, dd, 1'b0, "random");
        end
    endtask

    initial begin
        rst = 1'b0;
        z   = 9'd0;
        d   = 5'd8;
        test_reset();
        test_directed();
        test_input_ignore();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
